// File: rtl/input_fifo.sv
// First-word-fall-through flit FIFO with extra-MSB pointers for full/empty detection.
// Optional sticky overflow/underflow flag when INPUT_FIFO_ERR_FLAG_EN is defined.
module input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [2:0]            flit_id,
    output logic                  empty
`ifdef INPUT_FIFO_ERR_FLAG_EN
    ,
    output logic                  err
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  full, wr_fire, rd_fire;

    // Same index with differing wrap bit means every slot is occupied.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ready_out = ~full;
    assign wr_fire   = valid_in & ~full;
    assign rd_fire   = rd_en & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    assign data_out = mem[rd_ptr[AW-1:0]];
    assign flit_id  = data_out[DATA_WIDTH-1 -: 3];

`ifdef INPUT_FIFO_ERR_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= err | (valid_in & full) | (rd_en & empty);
    end
`endif

endmodule
